// File: rtl/cordic_nco_pkg.sv
// Shared types and constants for the CORDIC NCO front end.
// Holds the FSM state encoding, default phase width, dither LFSR constants and the latency helper.
package cordic_nco_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } nco_state_t;

    localparam int NCO_PH_W = 32;

    // Fibonacci LFSR, taps 16,14,13,11, shifting right: feedback bits 0,2,3,5.
    localparam logic [15:0] LFSR_SEED     = 16'hACE1;
    localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

    // One input register plus xy_sz-1 rotation stages.
    function automatic int cordic_lat(input int xy_sz);
        return xy_sz;
    endfunction

endpackage

// File: rtl/cordic_nco_lfsr.sv
// cordic_nco_lfsr: 16-bit Fibonacci LFSR supplying low-order phase dither.
// Latency: new value one cycle after advance; backpressure: none, holds while advance is low.
module cordic_nco_lfsr
    import cordic_nco_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             advance,
    output logic [OUT_W-1:0] dither
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (advance) begin
            lfsr_d = {^(lfsr_q & LFSR_TAP_MASK), lfsr_q[15:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/cordic_nco_ctrl.sv
// cordic_nco_ctrl: NCO phase stream and start vector for the CORDIC, plus result-valid tracking.
// Latency: outputs registered one cycle after each RUN cycle; res_valid trails sample_valid by LAT.
// Backpressure: config accepted only in IDLE via cfg_ready; phase dither built with CORDIC_NCO_DITHER_EN.
module cordic_nco_ctrl
    import cordic_nco_pkg::*;
#(
    parameter int XY_SZ       = 16,
    parameter int PH_W        = NCO_PH_W,
    parameter int DITHER_BITS = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [PH_W-1:0]         cfg_ftw,
    input  logic [PH_W-1:0]         cfg_phase,
    input  logic signed [XY_SZ-1:0] cfg_amp,
    input  logic                    enable,
    output logic [PH_W-1:0]         angle,
    output logic signed [XY_SZ-1:0] Xin,
    output logic signed [XY_SZ-1:0] Yin,
    output logic                    sample_valid,
    output logic                    res_valid,
    output logic                    busy
);

    localparam int LAT    = cordic_lat(XY_SZ);
    localparam int CNT_W  = $clog2(LAT);
    localparam int DITH_W = (DITHER_BITS > 0) ? DITHER_BITS : 1;

    nco_state_t              state_q, state_d;
    logic [PH_W-1:0]         acc_q, acc_d;
    logic [PH_W-1:0]         ftw_q, ftw_d;
    logic [PH_W-1:0]         phase_q, phase_d;
    logic signed [XY_SZ-1:0] amp_q, amp_d;
    logic                    cfg_loaded_q, cfg_loaded_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PH_W-1:0]         angle_q, angle_d;
    logic signed [XY_SZ-1:0] xin_q, xin_d;
    logic signed [XY_SZ-1:0] yin_q, yin_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic                    busy_q, busy_d;
    logic [LAT-1:0]          vld_pipe_q, vld_pipe_d;
    logic                    cfg_hs;
    logic [DITH_W-1:0]       dither_bits;

`ifdef CORDIC_NCO_DITHER_EN
    cordic_nco_lfsr #(
        .OUT_W (DITH_W)
    ) u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .advance (state_q == RUN),
        .dither  (dither_bits)
    );
`else
    assign dither_bits = '0;
`endif

    assign cfg_hs = cfg_valid && cfg_ready_q;

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        ftw_d          = ftw_q;
        phase_d        = phase_q;
        amp_d          = amp_q;
        cfg_loaded_d   = cfg_loaded_q;
        cnt_d          = cnt_q;
        angle_d        = angle_q;
        xin_d          = xin_q;
        yin_d          = yin_q;
        sample_valid_d = 1'b0;
        vld_pipe_d     = {vld_pipe_q[LAT-2:0], sample_valid_q};

        case (state_q)
            IDLE: begin
                if (cfg_hs) begin
                    ftw_d        = cfg_ftw;
                    phase_d      = cfg_phase;
                    amp_d        = cfg_amp;
                    cfg_loaded_d = 1'b1;
                end
                if (enable && (cfg_loaded_q || cfg_hs)) begin
                    state_d = RUN;
                    acc_d   = '0;
                end
            end
            RUN: begin
                if (enable) begin
                    angle_d        = acc_q + phase_q + PH_W'(dither_bits);
                    acc_d          = acc_q + ftw_q;
                    xin_d          = amp_q;
                    yin_d          = '0;
                    sample_valid_d = 1'b1;
                end else begin
                    // Drain LAT cycles so the last sample's result clears the rotator.
                    state_d = FLUSH;
                    cnt_d   = CNT_W'(LAT - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        cfg_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            ftw_q          <= '0;
            phase_q        <= '0;
            amp_q          <= '0;
            cfg_loaded_q   <= 1'b0;
            cnt_q          <= '0;
            angle_q        <= '0;
            xin_q          <= '0;
            yin_q          <= '0;
            sample_valid_q <= 1'b0;
            cfg_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            vld_pipe_q     <= '0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            ftw_q          <= ftw_d;
            phase_q        <= phase_d;
            amp_q          <= amp_d;
            cfg_loaded_q   <= cfg_loaded_d;
            cnt_q          <= cnt_d;
            angle_q        <= angle_d;
            xin_q          <= xin_d;
            yin_q          <= yin_d;
            sample_valid_q <= sample_valid_d;
            cfg_ready_q    <= cfg_ready_d;
            busy_q         <= busy_d;
            vld_pipe_q     <= vld_pipe_d;
        end
    end

    assign angle        = angle_q;
    assign Xin          = xin_q;
    assign Yin          = yin_q;
    assign sample_valid = sample_valid_q;
    assign res_valid    = vld_pipe_q[LAT-1];
    assign cfg_ready    = cfg_ready_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_cordic_nco_ctrl.sv
// Directed bench for cordic_nco_ctrl; the dither expectations follow CORDIC_NCO_DITHER_EN.
module tb_cordic_nco_ctrl;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               cfg_valid = 1'b0;
    logic               enable = 1'b0;
    logic [31:0]        cfg_ftw = '0;
    logic [31:0]        cfg_phase = '0;
    logic signed [15:0] cfg_amp = '0;
    logic               cfg_ready;
    logic [31:0]        angle;
    logic signed [15:0] Xin;
    logic signed [15:0] Yin;
    logic               sample_valid;
    logic               res_valid;
    logic               busy;

    int total = 0;
    int bad   = 0;

    cordic_nco_ctrl #(
        .XY_SZ       (16),
        .PH_W        (32),
        .DITHER_BITS (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_phase    (cfg_phase),
        .cfg_amp      (cfg_amp),
        .enable       (enable),
        .angle        (angle),
        .Xin          (Xin),
        .Yin          (Yin),
        .sample_valid (sample_valid),
        .res_valid    (res_valid),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    // Drop enable and wait (bounded) until the block is idle with an empty result pipe.
    task automatic drain(output bit ok);
        enable    = 1'b0;
        cfg_valid = 1'b0;
        ok        = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!busy && !res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({angle, Xin, Yin, sample_valid, res_valid, busy, cfg_ready} !== '0) begin
            bad++;
            $display("FAIL reset_values: angle=%h Xin=%0d Yin=%0d sv=%b rv=%b busy=%b rdy=%b, want all 0",
                     angle, Xin, Yin, sample_valid, res_valid, busy, cfg_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (cfg_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_before_edge: cfg_ready=%b want 0", cfg_ready);
        end
        tick();
        total++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_after_edge: cfg_ready=%b busy=%b sv=%b want 1 0 0",
                     cfg_ready, busy, sample_valid);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [31:0] exp_a;
        int errs;
        cfg_ftw   = 32'h0100_0000;
        cfg_phase = 32'h0;
        cfg_amp   = 16'sd19898;
        cfg_valid = 1'b1;
        enable    = 1'b1;
        tick();
        total++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1 || sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_entry: cfg_ready=%b busy=%b sv=%b want 0 1 0", cfg_ready, busy, sample_valid);
        end
        cfg_valid = 1'b0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_a = 32'(i) * 32'h0100_0000;
            total++;
            if (sample_valid !== 1'b1 || angle !== exp_a || Xin !== 16'sd19898 || Yin !== 16'sd0 ||
                res_valid !== (i >= 16)) begin
                bad++;
                $display("FAIL basic_sample%0d: sv=%b angle=%h Xin=%0d Yin=%0d rv=%b want 1 %h 19898 0 %b",
                         i, sample_valid, angle, Xin, Yin, res_valid, exp_a, (i >= 16));
            end
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL basic_drain: busy=%b rv=%b still set after bound", busy, res_valid);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [31:0] exp_a [5];
        exp_a[0] = 32'hC000_0000;
        exp_a[1] = 32'h0000_0000;
        exp_a[2] = 32'h4000_0000;
        exp_a[3] = 32'h8000_0000;
        exp_a[4] = 32'hC000_0000;
        cfg_ftw   = 32'h4000_0000;
        cfg_phase = 32'hC000_0000;
        cfg_amp   = 16'sd1000;
        cfg_valid = 1'b1;
        enable    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (sample_valid !== 1'b1 || angle !== exp_a[i]) begin
                bad++;
                $display("FAIL wrap_sample%0d: sv=%b angle=%h want 1 %h", i, sample_valid, angle, exp_a[i]);
            end
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wrap_drain: busy=%b rv=%b still set after bound", busy, res_valid);
        end
    endtask

    task automatic test_flush();
        bit ok;
        bit done;
        int pulses;
        int busy_cnt;
        int flush_err;
        cfg_ftw   = 32'h0000_0010;
        cfg_phase = 32'h0000_1000;
        cfg_amp   = -16'sd5;
        cfg_valid = 1'b1;
        enable    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(res_valid);
            total++;
            if (sample_valid !== 1'b1 || angle !== 32'h1000 + 32'h10 * 32'(i) || Xin !== -16'sd5) begin
                bad++;
                $display("FAIL flush_sample%0d: sv=%b angle=%h Xin=%0d want 1 %h -5",
                         i, sample_valid, angle, Xin, 32'h1000 + 32'h10 * 32'(i));
            end
        end
        enable    = 1'b0;
        busy_cnt  = 0;
        flush_err = 0;
        done      = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            pulses += int'(res_valid);
            if (busy) begin
                busy_cnt++;
                if (sample_valid || cfg_ready || angle !== 32'h1040) flush_err++;
                if (busy_cnt == 8) enable = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        total++;
        if (!done || busy_cnt != 16 || flush_err != 0) begin
            bad++;
            $display("FAIL flush_length: done=%b busy_cycles=%0d errs=%0d want 1 16 0", done, busy_cnt, flush_err);
        end
        total++;
        if (pulses != 5) begin
            bad++;
            $display("FAIL flush_res_pulses: got %0d want 5", pulses);
        end
        total++;
        if (cfg_ready !== 1'b1 || angle !== 32'h1040 || Xin !== -16'sd5) begin
            bad++;
            $display("FAIL flush_idle: cfg_ready=%b angle=%h Xin=%0d want 1 00001040 -5", cfg_ready, angle, Xin);
        end
        tick();
        total++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || sample_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_reenable_entry: busy=%b rdy=%b sv=%b want 1 0 0", busy, cfg_ready, sample_valid);
        end
        tick();
        total++;
        if (sample_valid !== 1'b1 || angle !== 32'h1000) begin
            bad++;
            $display("FAIL flush_restart: sv=%b angle=%h want 1 00001000", sample_valid, angle);
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL flush_drain: busy=%b rv=%b still set after bound", busy, res_valid);
        end
    endtask

    task automatic test_cfg_hold();
        bit ok;
        bit done;
        int rdy_err;
        cfg_ftw   = 32'h100;
        cfg_phase = 32'h5;
        cfg_amp   = 16'sd7;
        cfg_valid = 1'b1;
        enable    = 1'b1;
        tick();
        cfg_ftw   = 32'h300;
        cfg_phase = 32'h77;
        cfg_amp   = 16'sd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (cfg_ready !== 1'b0 || angle !== 32'h5 + 32'h100 * 32'(i) || Xin !== 16'sd7) begin
                bad++;
                $display("FAIL hold_run%0d: rdy=%b angle=%h Xin=%0d want 0 %h 7",
                         i, cfg_ready, angle, Xin, 32'h5 + 32'h100 * 32'(i));
            end
        end
        enable  = 1'b0;
        rdy_err = 0;
        done    = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (busy) begin
                if (cfg_ready) rdy_err++;
            end else begin
                done = 1'b1;
            end
        end
        total++;
        if (!done || rdy_err != 0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_flush_ready: done=%b early_ready=%0d rdy=%b want 1 0 1", done, rdy_err, cfg_ready);
        end
        cfg_ftw   = 32'h200;
        cfg_phase = 32'h9;
        cfg_amp   = 16'sd9;
        enable    = 1'b1;
        tick();
        total++;
        if (cfg_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL hold_accept: rdy=%b busy=%b want 0 1", cfg_ready, busy);
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (sample_valid !== 1'b1 || angle !== 32'h9 + 32'h200 * 32'(i) || Xin !== 16'sd9) begin
                bad++;
                $display("FAIL hold_newcfg%0d: sv=%b angle=%h Xin=%0d want 1 %h 9",
                         i, sample_valid, angle, Xin, 32'h9 + 32'h200 * 32'(i));
            end
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_drain: busy=%b rv=%b still set after bound", busy, res_valid);
        end
    endtask

    task automatic test_async_reset();
        int stray;
        enable = 1'b1;
        tick();
        for (int i = 0; i < 18; i++) tick();
        total++;
        if (res_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL areset_precond: rv=%b busy=%b want 1 1", res_valid, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({angle, Xin, Yin, sample_valid, res_valid, busy, cfg_ready} !== '0) begin
            bad++;
            $display("FAIL areset_immediate: angle=%h Xin=%0d Yin=%0d sv=%b rv=%b busy=%b rdy=%b, want all 0",
                     angle, Xin, Yin, sample_valid, res_valid, busy, cfg_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy || sample_valid || res_valid) stray++;
        end
        total++;
        if (stray != 0 || cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL areset_no_config_idle: active_cycles=%0d rdy=%b want 0 1", stray, cfg_ready);
        end
        enable = 1'b0;
    endtask

    task automatic test_dither();
        bit ok;
        logic [15:0] lfsr;
        logic [31:0] exp_a;
        cfg_ftw   = 32'h0;
        cfg_phase = 32'h0;
        cfg_amp   = 16'sd1;
        cfg_valid = 1'b1;
        enable    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        lfsr = 16'hACE1;
        for (int i = 0; i < 8; i++) begin
            tick();
`ifdef CORDIC_NCO_DITHER_EN
            exp_a = {24'h0, lfsr[7:0]};
            lfsr  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`else
            exp_a = 32'h0;
`endif
            total++;
            if (sample_valid !== 1'b1 || angle !== exp_a) begin
                bad++;
                $display("FAIL dither_sample%0d: sv=%b angle=%h want 1 %h", i, sample_valid, angle, exp_a);
            end
        end
        drain(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL dither_drain: busy=%b rv=%b still set after bound", busy, res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_flush();
        test_cfg_hold();
        test_async_reset();
        test_dither();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
